y86_pipe_ctrl: RTL and testbench
================================

# y86_pipe_ctrl

Pipeline control unit for the pipelined Y86-64 processor. Each cycle it decides stall and bubble for the F/D/E/M/W pipeline registers, using load/use, mispredicted-jump and `ret` hazards plus exception status. It owns the condition-code register read by the execute stage. It also runs the processor's run-state FSM (IDLE/RUN/HALT/FAULT) and keeps the cycle and retired-instruction counters.

## Interface
Parameters:
- CNT_W, 32, width of cycle_cnt and retired_cnt

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- go  in  1  single-cycle start pulse, honoured only in IDLE
- D_icode  in  4  icode in decode register
- d_srcA, d_srcB  in  4  decode source register IDs (15 = RNONE)
- E_icode  in  4  icode in execute register
- E_dstM  in  4  execute-stage memory destination
- e_cnd  in  1  branch condition from execute
- e_sf, e_zf, e_of  in  1  flags computed by execute this cycle
- M_icode  in  4  icode in memory register
- m_stat  in  4  memory-stage status
- W_icode  in  4  icode in writeback register
- W_stat  in  4  writeback status
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1  pipeline register controls
- set_cc  out  1  CC write enable this cycle
- cc_sf, cc_zf, cc_of  out  1  registered condition codes
- run_state  out  2  FSM state
- cycle_cnt, retired_cnt  out  CNT_W  performance counters

## Operation
- Status encoding is one-hot: SAOK=8, SHLT=4, SADR=2, SINS=1.
- Icodes: HALT 0, NOP 1, CMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSH 10, POP 11.
- Hazard terms:
  - load_use = E_icode∈{MRMOV,POP} && E_dstM≠15 && E_dstM∈{d_srcA,d_srcB}.
  - ret_pend = RET∈{D_icode,E_icode,M_icode}.
  - mispred = E_icode==JXX && !e_cnd.
  - exc_m = m_stat≠SAOK.
  - exc_w = W_stat≠SAOK.
- Controls in RUN:
  - F_stall = load_use | ret_pend.
  - D_stall = load_use.
  - D_bubble = mispred | (ret_pend & !load_use).
  - E_bubble = mispred | load_use.
  - M_bubble = exc_m | exc_w.
  - W_stall = exc_w.
- set_cc = RUN && E_icode==OPQ && !exc_m && !exc_w.
- CC register loads {e_sf,e_zf,e_of} on each edge where set_cc=1; otherwise it holds.
- FSM (terminal states are left only by reset):
  - IDLE -> RUN on go.
  - RUN -> HALT when W_stat==SHLT.
  - RUN -> FAULT when W_stat∈{SADR,SINS}.
  - HALT and FAULT are terminal.
- Encoding: IDLE 0, RUN 1, HALT 2, FAULT 3.
- Outside RUN:
  - F_stall = D_stall = W_stall = 1.
  - E_bubble = M_bubble = 1.
  - D_bubble = 0, set_cc = 0.
- Counters:
  - cycle_cnt increments every RUN cycle.
  - retired_cnt increments in RUN when W_stat==SAOK && W_icode≠NOP.
  - Both saturate at all-ones and freeze outside RUN.

## Timing
- Reset values:
  - run_state = IDLE.
  - cc_zf = 1, cc_sf = 0, cc_of = 0.
  - cycle_cnt = retired_cnt = 0.
  - Control outputs take their IDLE values immediately; reset is asynchronous.
- Stall/bubble and set_cc are combinational from inputs and run_state, valid in the same cycle.
- CC outputs reflect an OPq's flags one cycle after that OPq is in E. A following CMOV/JXX in E sees the updated flags.
- Priority of simultaneous events:
  - load_use with ret_pend: stall D, do not bubble it.
  - mispred with load_use: mispred can't co-occur (JXX has no dstM); E_bubble is asserted regardless.
  - exc_w and set_cc in the same cycle: set_cc is suppressed.
- The FSM transition on W_stat takes effect at the next edge. In that cycle W_stall=1 already, via exc_w.
- go outside IDLE is ignored. Reset mid-RUN returns to IDLE and clears the counters and CC.

## Structure
- y86_pkg holds:
  - icode constants;
  - stat encodings;
  - RNONE;
  - the run_state enum (IDLE/RUN/HALT/FAULT).
- Sub-module y86_hazard_detect is purely combinational. It produces load_use, ret_pend, mispred, exc_m and exc_w.
- The top level holds the FSM, CC register, counters and output muxing.

## Test plan
- Reset, no go for 5 cycles -> run_state=0, F_stall=1, cycle_cnt=0, cc={sf0,zf1,of0}. Then go pulse -> run_state=1 next cycle.
- E_icode=MRMOV, E_dstM=3, d_srcB=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0. Repeat with E_dstM=15 -> all four low.
- D_icode=RET -> F_stall=1, D_bubble=1 for three consecutive cycles as RET moves D->E->M.
- E_icode=JXX, e_cnd=0 -> D_bubble=E_bubble=1, F_stall=0.
- E_icode=OPQ, e_zf=0, e_sf=1 with m_stat=SAOK -> cc_sf=1, cc_zf=0 next cycle. Same with m_stat=SADR -> set_cc=0, CC unchanged.
- W_stat=SHLT, W_icode=HALT after 10 RUN cycles with 4 non-NOP retirements -> run_state=2, counters frozen at cycle_cnt=10, retired_cnt=4, all stalls asserted. Same with W_stat=SINS -> run_state=3.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline control slice: icodes, one-hot status,
// the "no register" ID and the run-state enum.
package y86_pkg;

   localparam logic [3:0] I_HALT  = 4'd0;
   localparam logic [3:0] I_NOP   = 4'd1;
   localparam logic [3:0] I_CMOV  = 4'd2;
   localparam logic [3:0] I_IRMOV = 4'd3;
   localparam logic [3:0] I_RMMOV = 4'd4;
   localparam logic [3:0] I_MRMOV = 4'd5;
   localparam logic [3:0] I_OPQ   = 4'd6;
   localparam logic [3:0] I_JXX   = 4'd7;
   localparam logic [3:0] I_CALL  = 4'd8;
   localparam logic [3:0] I_RET   = 4'd9;
   localparam logic [3:0] I_PUSH  = 4'd10;
   localparam logic [3:0] I_POP   = 4'd11;

   localparam logic [3:0] S_AOK = 4'd8;
   localparam logic [3:0] S_HLT = 4'd4;
   localparam logic [3:0] S_ADR = 4'd2;
   localparam logic [3:0] S_INS = 4'd1;

   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } run_state_e;

endpackage

// File: rtl/y86_hazard_detect.sv
// Combinational hazard terms for the Y86-64 pipeline; zero latency, no state.
// Only consumes stage contents, so it never exerts backpressure itself.
module y86_hazard_detect
   import y86_pkg::*;
(
   input  logic [3:0] D_icode_i,
   input  logic [3:0] d_srcA_i,
   input  logic [3:0] d_srcB_i,
   input  logic [3:0] E_icode_i,
   input  logic [3:0] E_dstM_i,
   input  logic       e_cnd_i,
   input  logic [3:0] M_icode_i,
   input  logic [3:0] m_stat_i,
   input  logic [3:0] W_stat_i,
   output logic       load_use_o,
   output logic       ret_pend_o,
   output logic       mispred_o,
   output logic       exc_m_o,
   output logic       exc_w_o
);

   logic e_is_load;

   assign e_is_load  = (E_icode_i == I_MRMOV) || (E_icode_i == I_POP);
   // RNONE in E_dstM must never match an unused source slot that also reads RNONE.
   assign load_use_o = e_is_load && (E_dstM_i != RNONE) &&
                       ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
   assign ret_pend_o = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
   assign mispred_o  = (E_icode_i == I_JXX) && !e_cnd_i;
   assign exc_m_o    = (m_stat_i != S_AOK);
   assign exc_w_o    = (W_stat_i != S_AOK);

endmodule

// File: rtl/y86_pipe_ctrl.sv
// Y86-64 pipeline control: combinational stall/bubble/set_cc, registered CC,
// run-state FSM and saturating perf counters; outside RUN the whole pipe is frozen.
module y86_pipe_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic [3:0]       D_icode,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_cnd,
   input  logic             e_sf,
   input  logic             e_zf,
   input  logic             e_of,
   input  logic [3:0]       M_icode,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       W_icode,
   input  logic [3:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc,
   output logic             cc_sf,
   output logic             cc_zf,
   output logic             cc_of,
   output logic [1:0]       run_state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic load_use, ret_pend, mispred, exc_m, exc_w;
   logic run;

   run_state_e       state_q;
   logic             sf_q, zf_q, of_q;
   logic             sf_d, zf_d, of_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   y86_hazard_detect u_hazard (
      .D_icode_i  (D_icode),
      .d_srcA_i   (d_srcA),
      .d_srcB_i   (d_srcB),
      .E_icode_i  (E_icode),
      .E_dstM_i   (E_dstM),
      .e_cnd_i    (e_cnd),
      .M_icode_i  (M_icode),
      .m_stat_i   (m_stat),
      .W_stat_i   (W_stat),
      .load_use_o (load_use),
      .ret_pend_o (ret_pend),
      .mispred_o  (mispred),
      .exc_m_o    (exc_m),
      .exc_w_o    (exc_w)
   );

   assign run = (state_q == ST_RUN);

   always_comb begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
      if (run) begin
         F_stall  = load_use | ret_pend;
         D_stall  = load_use;
         // A stalled D must hold its instruction, so load_use wins over the ret bubble.
         D_bubble = mispred | (ret_pend & ~load_use);
         E_bubble = mispred | load_use;
         M_bubble = exc_m | exc_w;
         W_stall  = exc_w;
         set_cc   = (E_icode == I_OPQ) && !exc_m && !exc_w;
      end
   end

   always_comb begin
      sf_d      = sf_q;
      zf_d      = zf_q;
      of_d      = of_q;
      cycle_d   = cycle_q;
      retired_d = retired_q;
      if (set_cc) begin
         sf_d = e_sf;
         zf_d = e_zf;
         of_d = e_of;
      end
      if (run) begin
         if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_ONE;
         if ((W_stat == S_AOK) && (W_icode != I_NOP) && (retired_q != CNT_MAX))
            retired_d = retired_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (go) state_q <= ST_RUN;
            ST_RUN: begin
               if (W_stat == S_HLT) state_q <= ST_HALT;
               else if ((W_stat == S_ADR) || (W_stat == S_INS)) state_q <= ST_FAULT;
            end
            default: state_q <= state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sf_q      <= 1'b0;
         zf_q      <= 1'b1;
         of_q      <= 1'b0;
         cycle_q   <= '0;
         retired_q <= '0;
      end else begin
         sf_q      <= sf_d;
         zf_q      <= zf_d;
         of_q      <= of_d;
         cycle_q   <= cycle_d;
         retired_q <= retired_d;
      end
   end

   assign cc_sf       = sf_q;
   assign cc_zf       = zf_q;
   assign cc_of       = of_q;
   assign run_state   = state_q;
   assign cycle_cnt   = cycle_q;
   assign retired_cnt = retired_q;

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Directed vector bench for y86_pipe_ctrl: control table in RUN plus hand sequences
// for reset, ret drain, CC update, halt/fault and counter freeze.
module tb_y86_pipe_ctrl;
   import y86_pkg::*;

   localparam int CNT_W = 32;
   localparam logic [6:0] CTRL_IDLE = 7'b1101110;

   logic clk = 1'b0;
   logic rst_n;
   logic go;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;
   logic e_cnd, e_sf, e_zf, e_of;
   logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
   logic cc_sf, cc_zf, cc_of;
   logic [1:0] run_state;
   logic [CNT_W-1:0] cycle_cnt, retired_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   y86_pipe_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .go(go),
      .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
      .e_sf(e_sf), .e_zf(e_zf), .e_of(e_of),
      .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
      .cc_sf(cc_sf), .cc_zf(cc_zf), .cc_of(cc_of),
      .run_state(run_state), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
   );

   wire [6:0] ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
   wire [2:0] cc   = {cc_sf, cc_zf, cc_of};

   typedef struct {
      logic [3:0] d_icode, srca, srcb, e_icode, e_dstm;
      logic       e_cnd;
      logic [3:0] m_icode, m_stat, w_stat;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic [3:0] di, sa, sb, ei, ed, input logic ec,
                               input logic [3:0] mi, ms, ws, input logic [6:0] ex);
      vec_t v;
      v.d_icode = di; v.srca = sa; v.srcb = sb; v.e_icode = ei; v.e_dstm = ed;
      v.e_cnd = ec; v.m_icode = mi; v.m_stat = ms; v.w_stat = ws; v.exp = ex;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic defaults();
      go = 1'b0;
      D_icode = I_NOP; d_srcA = RNONE; d_srcB = RNONE;
      E_icode = I_NOP; E_dstM = RNONE; e_cnd = 1'b1;
      e_sf = 1'b0; e_zf = 1'b0; e_of = 1'b0;
      M_icode = I_NOP; m_stat = S_AOK; W_icode = I_NOP; W_stat = S_AOK;
   endtask

   task automatic do_reset();
      @(negedge clk);
      defaults();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Pulse go in IDLE; returns at the negedge of the first RUN cycle.
   task automatic start_run();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   initial begin
      // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
      vecs[0]  = mk(I_NOP, RNONE, RNONE, I_NOP,   RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 7'b0000000);
      vecs[1]  = mk(I_NOP, RNONE, 4'd3,  I_MRMOV, 4'd3,  1'b1, I_NOP, S_AOK, S_AOK, 7'b1101000);
      vecs[2]  = mk(I_NOP, RNONE, 4'd3,  I_MRMOV, RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 7'b0000000);
      vecs[3]  = mk(I_NOP, 4'd5,  RNONE, I_POP,   4'd5,  1'b1, I_NOP, S_AOK, S_AOK, 7'b1101000);
      vecs[4]  = mk(I_NOP, 4'd5,  RNONE, I_OPQ,   4'd5,  1'b1, I_NOP, S_AOK, S_AOK, 7'b0000001);
      vecs[5]  = mk(I_RET, RNONE, RNONE, I_NOP,   RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 7'b1010000);
      vecs[6]  = mk(I_NOP, RNONE, RNONE, I_RET,   RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 7'b1010000);
      vecs[7]  = mk(I_NOP, RNONE, RNONE, I_NOP,   RNONE, 1'b1, I_RET, S_AOK, S_AOK, 7'b1010000);
      vecs[8]  = mk(I_RET, RNONE, 4'd3,  I_MRMOV, 4'd3,  1'b1, I_NOP, S_AOK, S_AOK, 7'b1101000);
      vecs[9]  = mk(I_NOP, RNONE, RNONE, I_JXX,   RNONE, 1'b0, I_NOP, S_AOK, S_AOK, 7'b0011000);
      vecs[10] = mk(I_NOP, RNONE, RNONE, I_JXX,   RNONE, 1'b1, I_NOP, S_AOK, S_AOK, 7'b0000000);
      vecs[11] = mk(I_NOP, RNONE, RNONE, I_OPQ,   RNONE, 1'b1, I_NOP, S_ADR, S_AOK, 7'b0000100);
      vecs[12] = mk(I_NOP, RNONE, RNONE, I_OPQ,   RNONE, 1'b1, I_NOP, S_AOK, S_INS, 7'b0000110);
      vecs[13] = mk(I_NOP, RNONE, RNONE, I_NOP,   RNONE, 1'b1, I_NOP, S_AOK, S_HLT, 7'b0000110);
      vecs[14] = mk(I_NOP, 4'd3,  4'd7,  I_MRMOV, 4'd3,  1'b1, I_NOP, S_INS, S_AOK, 7'b1101100);

      defaults();
      rst_n = 1'b0;
      #1;
      chk("reset_ctrl_async", 64'(ctrl), 64'(CTRL_IDLE));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset, idle for 5 cycles with no go.
      repeat (5) @(negedge clk);
      chk("idle_state", 64'(run_state), 64'(ST_IDLE));
      chk("idle_ctrl", 64'(ctrl), 64'(CTRL_IDLE));
      chk("idle_cycle_cnt", 64'(cycle_cnt), 64'd0);
      chk("reset_cc", 64'(cc), 64'(3'b010));
      start_run();
      chk("go_to_run", 64'(run_state), 64'(ST_RUN));

      // Control table, each vector applied within one RUN cycle then withdrawn before the edge.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         D_icode = vecs[i].d_icode; d_srcA = vecs[i].srca; d_srcB = vecs[i].srcb;
         E_icode = vecs[i].e_icode; E_dstM = vecs[i].e_dstm; e_cnd = vecs[i].e_cnd;
         M_icode = vecs[i].m_icode; m_stat = vecs[i].m_stat; W_stat = vecs[i].w_stat;
         #1;
         chk($sformatf("vec%0d_ctrl", i), 64'(ctrl), 64'(vecs[i].exp));
         #1;
         defaults();
      end
      @(negedge clk);
      chk("table_still_run", 64'(run_state), 64'(ST_RUN));

      // RET drains D -> E -> M with fetch stalled and D bubbled each cycle.
      D_icode = I_RET;
      #1 chk("ret_d", 64'({F_stall, D_bubble}), 64'(2'b11));
      @(negedge clk); D_icode = I_NOP; E_icode = I_RET;
      #1 chk("ret_e", 64'({F_stall, D_bubble}), 64'(2'b11));
      @(negedge clk); E_icode = I_NOP; M_icode = I_RET;
      #1 chk("ret_m", 64'({F_stall, D_bubble}), 64'(2'b11));
      @(negedge clk); M_icode = I_NOP;
      #1 chk("ret_gone", 64'({F_stall, D_bubble}), 64'(2'b00));

      // OPq updates CC one edge later; a memory exception suppresses the update.
      @(negedge clk);
      E_icode = I_OPQ; e_sf = 1'b1; e_zf = 1'b0; e_of = 1'b0;
      #1 chk("opq_set_cc", 64'(set_cc), 64'd1);
      @(negedge clk);
      chk("opq_cc_loaded", 64'(cc), 64'(3'b100));
      e_sf = 1'b0; e_zf = 1'b1; e_of = 1'b1; m_stat = S_ADR;
      #1 chk("opq_exc_m_set_cc", 64'(set_cc), 64'd0);
      @(negedge clk);
      chk("opq_exc_m_cc_hold", 64'(cc), 64'(3'b100));
      defaults();

      // 9 normal RUN cycles (4 retire), halt status in the 10th.
      do_reset();
      start_run();
      for (int i = 0; i < 9; i++) begin
         case (i)
            0: W_icode = I_OPQ;
            2: W_icode = I_IRMOV;
            4: W_icode = I_MRMOV;
            6: W_icode = I_CALL;
            default: W_icode = I_NOP;
         endcase
         @(negedge clk);
      end
      W_stat = S_HLT; W_icode = I_HALT;
      #1 chk("halt_wstall_same_cycle", 64'(W_stall), 64'd1);
      @(negedge clk);
      defaults();
      #1;
      chk("halt_state", 64'(run_state), 64'(ST_HALT));
      chk("halt_cycle_cnt", 64'(cycle_cnt), 64'd10);
      chk("halt_retired_cnt", 64'(retired_cnt), 64'd4);
      chk("halt_ctrl", 64'(ctrl), 64'(CTRL_IDLE));
      go = 1'b1; W_icode = I_OPQ; E_icode = I_OPQ;
      repeat (3) @(negedge clk);
      chk("halt_terminal", 64'(run_state), 64'(ST_HALT));
      chk("halt_counters_frozen", 64'({cycle_cnt, retired_cnt}), {32'd10, 32'd4});
      chk("halt_no_set_cc", 64'(set_cc), 64'd0);
      defaults();

      // Instruction fault in the first RUN cycle.
      do_reset();
      start_run();
      W_stat = S_INS; W_icode = I_OPQ;
      @(negedge clk);
      defaults();
      #1;
      chk("fault_state", 64'(run_state), 64'(ST_FAULT));
      chk("fault_cycle_cnt", 64'(cycle_cnt), 64'd1);
      chk("fault_retired_cnt", 64'(retired_cnt), 64'd0);

      // Asynchronous reset in the middle of RUN clears state, counters and CC.
      do_reset();
      start_run();
      E_icode = I_OPQ; e_sf = 1'b1; e_zf = 1'b0; e_of = 1'b1; W_icode = I_OPQ;
      @(negedge clk);
      defaults();
      chk("mid_cc_loaded", 64'(cc), 64'(3'b101));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_state", 64'(run_state), 64'(ST_IDLE));
      chk("mid_reset_counters", 64'({cycle_cnt, retired_cnt}), 64'd0);
      chk("mid_reset_cc", 64'(cc), 64'(3'b010));
      chk("mid_reset_ctrl", 64'(ctrl), 64'(CTRL_IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
